// File: rtl/fs_dither_engine.sv
// fs_dither_engine: in-place Floyd-Steinberg dithering of an 8-bit grayscale
// image held in SRAM. The engine drives port B of the pixel SRAM.
//
// A rising edge on start walks the image in row-major order. Each pixel takes
// four cycles: RD, WAIT, CALC and WR. The pixel is thresholded to 0x00 or 0xFF,
// written back in place, and its quantisation error is diffused to its
// neighbours. done then stays high until the next launch, an abort or a reset.
//
// Ports:
//   MAX10_CLK1_50 : sole clock, rising edge
//   rst_n         : asynchronous active-low reset
//   start         : run request, rising-edge sensitive
//   abort         : synchronous return to IDLE
//   busy / done   : run in progress / run complete
//   mem_addr      : port-B address (y*IMG_W + x)
//   mem_rden      : port-B read enable (RD only)
//   mem_wren      : port-B write enable (WR only)
//   mem_wdata     : port-B write data
//   mem_rdata     : port-B q, valid the cycle after the address is captured
module fs_dither_engine #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              MAX10_CLK1_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned EW = 9;   // error / row-buffer entry width
  localparam int unsigned VW = 11;  // pixel + accumulated error
  localparam int unsigned PW = 13;  // error * diffusion weight

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CALC,
    S_WR,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic              start_q;
  logic              launch_c;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [7:0]        pix;
  logic signed [EW-1:0] err_right;
  logic signed [EW-1:0] rows [2][IMG_W];
  logic              sel;
  logic              nsel;

  logic              busy_nxt;
  logic              done_nxt;
  logic              rden_nxt;
  logic              wren_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        wdata_nxt;

  logic              last_col;
  logic              last_row;
  logic [XW-1:0]     x_inc;
  logic [XW-1:0]     x_dec;
  logic signed [EW-1:0] cur_val;
  logic signed [VW-1:0] v;
  logic [7:0]        vc;
  logic [7:0]        q;
  logic signed [EW-1:0] e;
  logic signed [EW-1:0] d1, d3, d5, d7;

  // Floor of (e*k)/16; the product fits 13 bits, and the top 9 bits hold the result.
  function automatic logic signed [EW-1:0] diff(input logic signed [EW-1:0] ev,
                                                input logic [3:0] k);
    logic signed [PW-1:0] p;
    p = $signed({{(PW-EW){ev[EW-1]}}, ev}) * $signed({{(PW-4){1'b0}}, k});
    return p[PW-1:4];
  endfunction

  assign launch_c = start & ~start_q;
  assign last_col = (x == XW'(IMG_W - 1));
  assign last_row = (y == YW'(IMG_H - 1));
  assign x_inc    = x + XW'(1);
  assign x_dec    = x - XW'(1);
  assign nsel     = ~sel;

  // Quantise the current pixel and derive the diffusion terms
  always_comb begin
    cur_val = rows[sel][x];
    v = $signed({3'b000, pix})
      + $signed({{(VW-EW){err_right[EW-1]}}, err_right})
      + $signed({{(VW-EW){cur_val[EW-1]}}, cur_val});
    if (v[VW-1])              vc = 8'h00;
    else if (v > 11'sd255)    vc = 8'hFF;
    else                      vc = v[7:0];
    q  = vc[7] ? 8'hFF : 8'h00;
    e  = $signed({1'b0, vc}) - $signed({1'b0, q});
    d1 = diff(e, 4'd1);
    d3 = diff(e, 4'd3);
    d5 = diff(e, 4'd5);
    d7 = diff(e, 4'd7);
  end

  // Start-edge history
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  end

  // State register
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = done;
    rden_nxt  = 1'b0;
    wren_nxt  = 1'b0;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    if (abort) begin
      state_nxt = S_IDLE;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch_c) begin
            state_nxt = S_RD;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
            rden_nxt  = 1'b1;
            addr_nxt  = '0;
          end
        end
        S_RD:   state_nxt = S_WAIT;
        S_WAIT: state_nxt = S_CALC;
        S_CALC: begin
          state_nxt = S_WR;
          wren_nxt  = 1'b1;
          wdata_nxt = q;
        end
        S_WR: begin
          if (last_col && last_row) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_RD;
            rden_nxt  = 1'b1;
            addr_nxt  = mem_addr + ADDR_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      busy      <= busy_nxt;
      done      <= done_nxt;
      mem_rden  <= rden_nxt;
      mem_wren  <= wren_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

  // Pixel position, pixel latch, error carry and ping-pong row buffers
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      pix       <= '0;
      err_right <= '0;
      sel       <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        rows[0][i] <= '0;
        rows[1][i] <= '0;
      end
    end else if (!abort) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch_c) begin
            x         <= '0;
            y         <= '0;
            err_right <= '0;
            sel       <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
              rows[0][i] <= '0;
              rows[1][i] <= '0;
            end
          end
        end
        S_WAIT: pix <= mem_rdata;
        S_CALC: begin
          err_right <= last_col ? '0 : d7;
          // The last row has no row below it, so its contributions are dropped.
          if (!last_row) begin
            if (x != '0) rows[nsel][x_dec] <= rows[nsel][x_dec] + d3;
            rows[nsel][x] <= rows[nsel][x] + d5;
            if (!last_col) rows[nsel][x_inc] <= rows[nsel][x_inc] + d1;
          end
        end
        S_WR: begin
          if (last_col) begin
            // Swap the buffers. The old current row becomes the cleared next row.
            x         <= '0;
            y         <= y + YW'(1);
            err_right <= '0;
            sel       <= nsel;
            for (int i = 0; i < IMG_W; i++) rows[sel][i] <= '0;
          end else begin
            x <= x_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fs_dither_engine.sv
// Bench for fs_dither_engine. It uses a 4x2 image and an SRAM model.
// A whole-image error-field reference model predicts every write.
// A negedge monitor checks writes and read timing against a scoreboard.
module tb_fs_dither_engine;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, mem_rden, mem_wren;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic          pa_we = 1'b0;
  logic [AW-1:0] pa_addr = '0;
  logic [7:0]    pa_data = '0;
  logic [7:0]    sram [N];

  int img_ref [N];
  int exp_out [N];
  int gold [N];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  bit run_on = 1'b0;

  typedef struct {
    int addr;
    int data;
    int at;
  } wr_t;
  wr_t sbq [$];

  always #5 clk = ~clk;

  fs_dither_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(16)) dut (
    .MAX10_CLK1_50(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_rden(mem_rden),
    .mem_wren(mem_wren),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Cycle counter plus the SRAM: port A for loading, port B for the engine
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pa_we) sram[pa_addr] <= pa_data;
    else if (mem_wren) sram[mem_addr[AW-1:0]] <= mem_wdata;
    if (mem_rden) mem_rdata <= sram[mem_addr[AW-1:0]];
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: check each write against the scoreboard and check read timing
  always @(negedge clk) begin
    wr_t ent;
    if (mem_wren) begin
      if (sbq.size() == 0) chk("wr_unexpected", int'(mem_wren), 0);
      else begin
        ent = sbq.pop_front();
        chk("wr_addr", int'(mem_addr), ent.addr);
        chk("wr_data", int'(mem_wdata), ent.data);
        chk("wr_cycle", cyc, ent.at);
      end
    end
    if (mem_rden) begin
      chk("rd_during_run", int'(run_on), 1);
      if (run_on) begin
        chk("rd_phase", (cyc - t0) % 4, 0);
        chk("rd_addr", int'(mem_addr), (cyc - t0) / 4);
      end
    end
  end

  // Reference: a full-image error field with classic FS weights and floor shifts
  function automatic void model();
    int err [N];
    int v, q, e, i;
    foreach (err[k]) err[k] = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        i = y * W + x;
        v = img_ref[i] + err[i];
        if (v < 0) v = 0;
        else if (v > 255) v = 255;
        q = (v >= 128) ? 255 : 0;
        e = v - q;
        if (x < W - 1) err[i + 1] += (e * 7) >>> 4;
        if (y < H - 1) begin
          if (x > 0) err[i + W - 1] += (e * 3) >>> 4;
          err[i + W] += (e * 5) >>> 4;
          if (x < W - 1) err[i + W + 1] += e >>> 4;
        end
        exp_out[i] = q;
      end
    end
  endfunction

  task automatic load_ref();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      pa_we   = 1'b1;
      pa_addr = AW'(k);
      pa_data = 8'(img_ref[k]);
    end
    @(negedge clk);
    pa_we = 1'b0;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    model();
    @(posedge clk);
    #1;
    t0 = cyc;
    run_on = 1'b1;
    chk("launch_busy", int'(busy), 1);
    chk("launch_done", int'(done), 0);
    for (int k = 0; k < N; k++) sbq.push_back('{k, exp_out[k], t0 + 4 * k + 3});
  endtask

  task automatic finish_run(input bit hold);
    int k;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", int'(done), 1);
    chk("done_cycle", cyc - t0, 4 * N);
    chk("busy_end", int'(busy), 0);
    chk("sb_drained", sbq.size(), 0);
    run_on = 1'b0;
    if (hold) begin
      repeat (20) @(negedge clk);
      chk("done_held", int'(done), 1);
      chk("no_rerun_busy", int'(busy), 0);
    end
    start = 1'b0;
    sbq.delete();
  endtask

  task automatic check_model();
    for (int k = 0; k < N; k++) chk("mem_vs_model", int'(sram[k]), exp_out[k]);
  endtask

  task automatic check_gold();
    for (int k = 0; k < N; k++) chk("mem_golden", int'(sram[k]), gold[k]);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rden"}, int'(mem_rden), 0);
    chk({tag, "_wren"}, int'(mem_wren), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gold = '{255, 0, 255, 0, 0, 255, 0, 255};
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_addr", int'(mem_addr), 0);
    chk("reset_wdata", int'(mem_wdata), 0);
    rst_n = 1'b1;

    // Mid-gray image; the engine must not rerun while start stays high afterwards
    foreach (img_ref[k]) img_ref[k] = 128;
    load_ref();
    launch();
    finish_run(1'b1);
    check_gold();

    // Uniform black and white images
    foreach (img_ref[k]) img_ref[k] = 0;
    load_ref();
    launch();
    finish_run(1'b0);
    check_model();
    for (int k = 0; k < N; k++) chk("uniform_00", int'(sram[k]), 0);

    foreach (img_ref[k]) img_ref[k] = 255;
    load_ref();
    launch();
    finish_run(1'b0);
    for (int k = 0; k < N; k++) chk("uniform_ff", int'(sram[k]), 255);

    // Clamp cases: near-white row 0, then 0x7F followed by 0xFF
    img_ref = '{250, 250, 250, 250, 127, 255, 0, 0};
    img_ref[6] = int'($urandom_range(255));
    img_ref[7] = int'($urandom_range(255));
    load_ref();
    launch();
    finish_run(1'b0);
    check_model();
    for (int k = 0; k < W; k++) chk("clamp_row0", int'(sram[k]), 255);
    chk("clamp_pos", int'(sram[5]), 255);

    // Random images
    for (int r = 0; r < 8; r++) begin
      foreach (img_ref[k]) img_ref[k] = int'($urandom_range(255));
      load_ref();
      launch();
      finish_run(1'b0);
      check_model();
    end

    // Abort in CALC of pixel 2
    foreach (img_ref[k]) img_ref[k] = 128;
    load_ref();
    launch();
    while (cyc < t0 + 10) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("abort");
    chk("abort_no_wr2", sbq.size(), N - 2);
    sbq.delete();
    run_on = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_done_low", int'(done), 0);
    load_ref();
    launch();
    finish_run(1'b0);
    check_gold();

    // Asynchronous reset during pixel 3
    load_ref();
    launch();
    while (cyc < t0 + 13) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_idle_outputs("midreset");
    chk("midreset_addr", int'(mem_addr), 0);
    chk("midreset_wdata", int'(mem_wdata), 0);
    chk("midreset_writes", sbq.size(), N - 3);
    sbq.delete();
    run_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_ref();
    launch();
    finish_run(1'b0);
    check_gold();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fs_dither_engine.md
# fs_dither_engine

Floyd–Steinberg dithering engine that runs on port B of the pixel SRAM between the SPI ingest phase and the SPI read-back phase. On a start edge it walks the stored 8-bit grayscale image in row-major order, thresholds each pixel to 0x00/0xFF and diffuses the quantisation error. It writes each result back in place, then raises `done`. `done` is the signal the SPI transaction logic uses as its read-enable to begin streaming.

## Interface
- `IMG_W`, default 256: image width in pixels (≥2).
- `IMG_H`, default 256: image height in rows (≥1).
- `ADDR_W`, default 16: SRAM address width; IMG_W·IMG_H ≤ 2^ADDR_W.

- `MAX10_CLK1_50`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; only a rising edge (start=1, previous sample 0) launches a run.
- `abort`  in  1  synchronous; returns to IDLE next edge.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run completion until the next launch, abort or reset.
- `mem_addr`  out  ADDR_W  port-B address, y·IMG_W + x.
- `mem_rden`  out  1  port-B read enable.
- `mem_wren`  out  1  port-B write enable.
- `mem_wdata`  out  8  port-B write data.
- `mem_rdata`  in  8  port-B q; valid the cycle after the address is captured.

## Operation
- States: IDLE, RD, WAIT, CALC, WR, DONE.
- IDLE/DONE + start edge → RD with x=y=0. Clear `err_right` and both error-row buffers.
- RD → WAIT → CALC → WR → (RD for next pixel | DONE after pixel (IMG_W-1, IMG_H-1)).
- `mem_addr` is held constant from RD through WR.
  - `mem_rden` is high only in RD.
  - `mem_wren` is high only in WR.
- At the end of WAIT, `mem_rdata` is registered as `pix`.
- CALC:
  - v = pix + err_right + cur_row[x], signed 11-bit.
  - vc = clamp(v, 0, 255).
  - q = (vc ≥ 128) ? 255 : 0.
  - e = vc − q, signed 9-bit, range [−127, 127].
  - `mem_wdata` ← q.
- Diffusion uses d(k) = (e·k) >>> 4 (arithmetic shift, floor):
  - err_right ← d(7) if x < IMG_W-1, else 0.
  - nxt_row[x-1] += d(3) if x > 0.
  - nxt_row[x] += d(5).
  - nxt_row[x+1] += d(1) if x < IMG_W-1.
- Row buffers are IMG_W × signed 9-bit entries, ping-pong.
  - At the end of each row: cur_row ↔ nxt_row; the new nxt_row is cleared to 0; err_right ← 0.
  - On the last row, nxt_row contributions are discarded.
- `abort` in any state: next edge goes to IDLE; busy, done, mem_rden and mem_wren go to 0. A write in progress in the abort cycle is not issued if abort is sampled before WR. No partial-state retention: the next start restarts at pixel 0.
- A start edge during a run is ignored.
- A start edge in DONE relaunches: done falls at the same edge busy rises.
- Reset mid-run behaves like abort but is asynchronous.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, mem_rden=0, mem_wren=0, mem_addr=0, mem_wdata=0.
  - start-edge history = 0.
- Start edge sampled at clock edge 0 gives pixel n:
  - RD in [4n, 4n+1), with mem_addr = n.
  - pix registered at edge 4n+2.
  - wdata registered at edge 4n+3.
  - mem_wren high in [4n+3, 4n+4).
- Throughput: exactly 4 cycles/pixel, no stalls.
- busy rises at edge 0. For N = IMG_W·IMG_H, busy falls and done rises at edge 4N.
- `mem_addr` never exceeds N−1; no wrap.
- Port A may write concurrently only while busy=0. The engine assumes exclusive port-B access while busy=1.

## Test plan
- Reset: assert rst_n=0 mid-run (pixel 3 of 8) → all outputs 0 in the same cycle. After release, the next start edge reads address 0 first.
- IMG_W=4, IMG_H=2, all pixels 0x80, start → SRAM reads back 255,0,255,0,0,255,0,255. Intermediate errors: err_right after pixel 0 = −56; row-1 cur_row = −27,−4,−10,20.
- Uniform 0x00 image → all 0x00. Uniform 0xFF image → all 0xFF; e=0 everywhere.
- 4×2 cycle check: mem_rden pulses at edges 0,4,…,28. mem_wren is high in [3,4),…,[31,32). done rises at edge 32. start held high after completion causes no rerun.
- Clamp: row 0 = 250,250,250,250 (W=4, H=1) → pixel 0: v=250, q=255, e=−5. Then v = 250 + d(7)(−5 → −3) = 247 → 255. Force a positive case with 0x7F,0xFF: v = 255 + 55 → vc=255 → 0xFF, e=0.
- abort asserted in CALC of pixel 2 → no mem_wren for pixel 2; IDLE next edge; done stays 0. A fresh start edge reproduces the full golden output.
